// File: rtl/gpiotest_pkg.sv
// Shared definitions for the GPIO test pattern generator and its receiver.
// Both sides take their pulse timing from here so they cannot drift apart.
package gpiotest_pkg;

  localparam int PIN_ID_W = 6;

  // Pulse-train protocol: pin N sends N pulses of PULSE_HI_US high and
  // PULSE_LO_US low, then holds the line low for at least GAP_US.
  localparam int PULSE_HI_US = 10;
  localparam int PULSE_LO_US = 10;
  localparam int GAP_US      = 1_000;
  localparam int STUCK_US    = 100_000;

  typedef enum logic [1:0] {IDLE, ARMED, BURST, CHECK} rx_state_t;

  // Microseconds to clock cycles; 64-bit intermediate keeps 100 ms at tens of MHz in range.
  function automatic int us_to_cyc(input int clock_hz, input int us);
    return int'((longint'(clock_hz) * longint'(us)) / longint'(1_000_000));
  endfunction

endpackage

// File: rtl/gpiotest_sync_filter.sv
// Two-flop synchronizer plus glitch filter for one asynchronous input pin.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous pin
//   level      : filtered level; follows din only after FILT_CYC identical
//                synchronized samples that differ from the current level
//   rise, fall : one-cycle strobes, asserted in the cycle level changes
module gpiotest_sync_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      // Any sample agreeing with the current level restarts the run.
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          rise  <= sync[1];
          fall  <= ~sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gpiotest_probe_rx.sv
// Receiver for the GPIO pulse-train ID pattern on a single probe pin.
// Counts filtered pulses per burst and reports the pin ID once two
// consecutive bursts agree.
//   clk, reset   : system clock, synchronous active-high reset
//   probe_in     : asynchronous probe pin
//   pin_id       : last confirmed pulse count
//   id_valid     : pin_id confirmed by two matching consecutive bursts
//   id_strobe    : one-cycle pulse when pin_id/id_valid changes
//   err_overflow : sticky, a burst exceeded MAX_PULSES (cleared by reset only)
//   stuck_high   : filtered level high for STUCK_CYC cycles
//   activity     : one-cycle pulse per accepted rising edge
module gpiotest_probe_rx
  import gpiotest_pkg::*;
#(
  parameter int CLOCK_HZ   = 12_000_000,
  parameter int FILT_CYC   = 4,
  parameter int GAP_CYC    = us_to_cyc(CLOCK_HZ, GAP_US),
  parameter int STUCK_CYC  = us_to_cyc(CLOCK_HZ, STUCK_US),
  parameter int MAX_PULSES = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                probe_in,
  output logic [PIN_ID_W-1:0] pin_id,
  output logic                id_valid,
  output logic                id_strobe,
  output logic                err_overflow,
  output logic                stuck_high,
  output logic                activity
);
  localparam int LW = $clog2(GAP_CYC + 1);
  localparam int HW = $clog2(STUCK_CYC + 1);
  localparam logic [LW-1:0]       GAP_END   = LW'(GAP_CYC);
  localparam logic [HW-1:0]       STUCK_END = HW'(STUCK_CYC);
  localparam logic [HW-1:0]       STUCK_PRE = HW'(STUCK_CYC - 1);
  localparam logic [PIN_ID_W-1:0] MAX_P     = PIN_ID_W'(MAX_PULSES);
  localparam logic [PIN_ID_W-1:0] CNT_SAT   = PIN_ID_W'(MAX_PULSES + 1);

  logic level, rise, fall;

  gpiotest_sync_filter #(.FILT_CYC(FILT_CYC)) u_filt (
    .clk   (clk),
    .reset (reset),
    .din   (probe_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign activity = rise;

  logic [LW-1:0]       low_cnt;
  logic [HW-1:0]       high_cnt;
  logic [PIN_ID_W-1:0] pulse_cnt, prev_cnt;
  rx_state_t           state;
  logic                stuck_hit;

  // Saturating run-length counters of the filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      if (level)                  low_cnt <= '0;
      else if (low_cnt != GAP_END) low_cnt <= low_cnt + 1'b1;
      if (!level)                     high_cnt <= '0;
      else if (high_cnt != STUCK_END) high_cnt <= high_cnt + 1'b1;
    end
  end

  // Fires only in the cycle high_cnt steps onto STUCK_CYC, so it is one-shot
  // even though the counter then sits saturated.
  assign stuck_hit = level && (high_cnt == STUCK_PRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      prev_cnt     <= '0;
      pin_id       <= '0;
      id_valid     <= 1'b0;
      id_strobe    <= 1'b0;
      err_overflow <= 1'b0;
      stuck_high   <= 1'b0;
    end else begin
      id_strobe <= 1'b0;
      if (fall) stuck_high <= 1'b0;
      if (stuck_hit) begin
        // Takes priority over burst end; history is dropped so the ID must
        // be re-confirmed by two fresh bursts after release.
        stuck_high <= 1'b1;
        id_valid   <= 1'b0;
        id_strobe  <= id_valid;
        prev_cnt   <= '0;
        state      <= IDLE;
      end else begin
        unique case (state)
          IDLE:  if (low_cnt == GAP_END) state <= ARMED;
          ARMED: if (rise) begin
            pulse_cnt <= PIN_ID_W'(1);
            state     <= BURST;
          end
          BURST: begin
            if (rise && pulse_cnt != CNT_SAT) pulse_cnt <= pulse_cnt + 1'b1;
            if (low_cnt == GAP_END) state <= CHECK;
          end
          CHECK: begin
            state    <= ARMED;
            prev_cnt <= pulse_cnt;
            if (pulse_cnt > MAX_P) begin
              err_overflow <= 1'b1;
              id_valid     <= 1'b0;
              id_strobe    <= id_valid;
              prev_cnt     <= '0;
            end else if (pulse_cnt == prev_cnt) begin
              id_valid  <= 1'b1;
              pin_id    <= pulse_cnt;
              id_strobe <= !id_valid || (pin_id != pulse_cnt);
            end else begin
              id_valid  <= 1'b0;
              id_strobe <= id_valid;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpiotest_probe_rx.sv
module tb_gpiotest_probe_rx;
  localparam int FILT = 4, GAP = 64, STUCK = 1000, MAXP = 32;

  logic       clk = 1'b0, reset = 1'b1, probe_in = 1'b0;
  logic [5:0] pin_id;
  logic       id_valid, id_strobe, err_overflow, stuck_high, activity;

  int total = 0, bad = 0;
  int n_str = 0, n_act = 0;

  // Reference model state: burst-level decode rules, not cycle-level.
  int m_prev = 0, m_pin = 0, m_str = 0, m_act = 0;
  bit m_valid = 0, m_ovf = 0;

  always #5 clk = ~clk;

  gpiotest_probe_rx #(
    .FILT_CYC(FILT), .GAP_CYC(GAP), .STUCK_CYC(STUCK), .MAX_PULSES(MAXP)
  ) dut (
    .clk(clk), .reset(reset), .probe_in(probe_in),
    .pin_id(pin_id), .id_valid(id_valid), .id_strobe(id_strobe),
    .err_overflow(err_overflow), .stuck_high(stuck_high), .activity(activity)
  );

  always @(negedge clk) begin
    if (id_strobe) n_str++;
    if (activity)  n_act++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      probe_in = v;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pin_id"},   int'(pin_id),       m_pin);
    chk({tag, ".id_valid"}, int'(id_valid),     int'(m_valid));
    chk({tag, ".overflow"}, int'(err_overflow), int'(m_ovf));
    chk({tag, ".stuck"},    int'(stuck_high),   0);
    chk({tag, ".strobes"},  n_str,              m_str);
    chk({tag, ".activity"}, n_act,              m_act);
  endtask

  task automatic model_reset();
    m_prev = 0; m_pin = 0; m_valid = 0; m_ovf = 0;
  endtask

  // One burst of n pulses with random widths, optional 2-cycle glitches in the
  // low phases, followed by a 100-cycle gap; then the model absorbs the burst.
  task automatic burst(input int n, input bit glitch, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, int'($urandom_range(12, 5)));
      if (glitch && i < n - 1) begin
        drive(1'b0, 5); drive(1'b1, 2); drive(1'b0, 5);
      end else begin
        drive(1'b0, int'($urandom_range(12, 5)));
      end
    end
    drive(1'b0, 100);
    m_act += n;
    if (n > MAXP) begin
      m_ovf = 1; if (m_valid) m_str++; m_valid = 0; m_prev = 0;
    end else if (n == m_prev) begin
      if (!m_valid || m_pin != n) m_str++;
      m_valid = 1; m_pin = n; m_prev = n;
    end else begin
      if (m_valid) m_str++;
      m_valid = 0; m_prev = n;
    end
    check_all(tag);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    drive(1'b0, 100);

    burst(5, 0, "b5a");
    burst(5, 0, "b5b");
    chk("b5b.pin_is_5", int'(pin_id), 5);
    burst(7, 0, "b7a");
    burst(7, 0, "b7b");

    burst(3, 1, "glitch_a");
    burst(3, 1, "glitch_b");
    chk("glitch.pin_is_3", int'(pin_id), 3);

    burst(40, 0, "ovf40");
    burst(4, 0, "post_ovf_a");
    burst(4, 0, "post_ovf_b");

    for (int k = 0; k < 6; k++) begin
      n = ($urandom_range(1, 0) == 1) ? m_prev : int'($urandom_range(34, 1));
      if (n == 0) n = 1;
      burst(n, 0, $sformatf("rnd%0d", k));
    end

    // Ensure a valid ID before the stuck-high test.
    burst(9, 0, "pre_stuck_a");
    burst(9, 0, "pre_stuck_b");
    drive(1'b1, 990);
    m_act += 1;
    chk("stuck.early", int'(stuck_high), 0);
    drive(1'b1, 30);
    if (m_valid) m_str++;
    m_valid = 0; m_prev = 0;
    chk("stuck.set",      int'(stuck_high), 1);
    chk("stuck.id_valid", int'(id_valid),   0);
    chk("stuck.strobes",  n_str,            m_str);
    chk("stuck.activity", n_act,            m_act);
    drive(1'b1, 180);
    drive(1'b0, 20);
    chk("stuck.release", int'(stuck_high), 0);
    drive(1'b0, 80);
    burst(5, 0, "post_stuck_a");
    burst(5, 0, "post_stuck_b");

    // Reset after 3 of 6 pulses; the remainder must not be decoded.
    for (int i = 0; i < 3; i++) begin drive(1'b1, 8); drive(1'b0, 8); end
    m_act += 3;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk("midrst.pin_id",   int'(pin_id),       0);
    chk("midrst.id_valid", int'(id_valid),     0);
    chk("midrst.strobe",   int'(id_strobe),    0);
    chk("midrst.overflow", int'(err_overflow), 0);
    chk("midrst.stuck",    int'(stuck_high),   0);
    chk("midrst.activity", int'(activity),     0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 8); drive(1'b0, 8); end
    m_act += 3;
    drive(1'b0, 100);
    check_all("midrst.remainder");
    burst(6, 0, "b6a");
    burst(6, 0, "b6b");
    chk("b6b.pin_is_6", int'(pin_id), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
